core_exu_mul_ctrl: RTL and testbench
====================================

Name: core_exu_mul_ctrl

Overview:
Sequencing controller for the RV32M multiply path in the EXU. It accepts one MUL/MULH/MULHSU/MULHU request, converts operands to magnitudes and a sign flag, and drives the unsigned-magnitude multiplier core_exu_mul. It registers the 64-bit product, selects the low or high word, and holds the result under a valid/ready handshake toward writeback. It also handles pipeline flush and stalls the issue stage through busy_o.

Parameters:
XLEN, `DATA_BUS_WIDTH (32), operand/result width; only 32 is supported.

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
start_i  in  1  request strobe; sampled only when busy_o=0 or on DONE&ready_i
op_i  in  2  funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
rs1_i  in  XLEN  operand 1
rs2_i  in  XLEN  operand 2
flush_i  in  1  kill in-flight op (branch mispredict/trap)
ready_i  in  1  writeback accepts result
busy_o  out  1  controller cannot accept start_i this cycle
valid_o  out  1  result_o valid
result_o  out  XLEN  selected 32-bit result

Behaviour:
- States: IDLE, CALC, DONE. Reset: state=IDLE, busy_o=0, valid_o=0, result_o=0, all internal registers 0.
- IDLE: on start_i=1 (and flush_i=0), go to CALC. Latch |rs1|, |rs2|, sign flag, and hi_sel=(op_i!=00).
- Operand treatment: rs1 is signed for op 01 and 10. rs2 is signed for op 01 only. All other cases are unsigned.
- MUL (00) is treated as unsigned; its low word is identical either way.
- Magnitude: neg = signed & x[31]; mag = neg ? (~x+1) : x. The value 0x80000000 maps to magnitude 0x80000000, read as unsigned; this is correct.
- sign = neg1 ^ neg2, driven into core_exu_mul.sign_i. Its data1_i/data2_i are fed only from the latched magnitude registers, never from the inputs directly.
- CALC: exactly one cycle. Capture core_exu_mul.data_o into a 64-bit product register and go to DONE.
- DONE: valid_o=1. result_o = hi_sel ? prod[63:32] : prod[31:0], driven from a register and stable while valid_o=1 and ready_i=0.
  - ready_i=1 and start_i=0: go to IDLE.
  - ready_i=1 and start_i=1: back-to-back. Latch the new operands and go to CALC.
  - ready_i=0: hold; start_i is ignored.
- Latency: start accepted in cycle N gives valid_o=1 in cycle N+2. Throughput is one op per 2 cycles with ready_i held high.
- busy_o = (state==CALC) | (state==DONE & ~ready_i). It is combinational from state and ready_i.
- flush_i=1 in any state: next state IDLE, valid_o=0 next cycle. A start_i in the same cycle is dropped. Flush has priority over ready_i and start_i.
- A result accepted (valid_o&ready_i) in the same cycle as flush_i counts as delivered; writeback owns discarding it.
- rst_n low mid-operation: immediate return to reset values. No result is produced and there is no residual valid.
- op_i and rs*_i are don't-care outside accept cycles.

Decomposition:
- Op codes MUL_OP_MUL/MULH/MULHSU/MULHU (2'b00..2'b11) and the state encodings go into chip_param.v as `defines.
- One sub-module instance: core_exu_mul (unsigned-magnitude multiply with sign_i-controlled negation).
- The magnitude/sign logic stays inline.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, ready_i=1 -> valid_o at N+2 with result_o=0xFFFFFFEB; busy_o=1 at N+1 only.
- MULH rs1=0x80000000, rs2=0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU rs1=0xFFFFFFFF (−1), rs2=0xFFFFFFFF -> 0xFFFFFFFF. MULH rs1=0, rs2=0x80000000 -> 0x00000000 (no −0 artefact).
- Backpressure: ready_i=0 for 5 cycles in DONE -> valid_o and result_o stable, busy_o=1, a start_i pulse is ignored. Then ready_i=1 with start_i=1 (MULHU 3×5) -> the next valid_o two cycles later has result_o=0x00000000.
- flush_i asserted in CALC -> IDLE next cycle, valid_o never rises. flush_i with start_i in IDLE -> no op launched.
- rst_n deasserted low asynchronously mid-CALC -> valid_o=0, result_o=0, busy_o=0 immediately. After rst_n release, a fresh MUL 2×3 gives 0x00000006.

Source files
------------

// File: rtl/core_exu_mul_ctrl_pkg.sv
// Shared definitions for the RV32M multiply controller: widths, op codes,
// FSM state encoding and the operand-signedness / magnitude helpers.
package core_exu_mul_ctrl_pkg;

    localparam int DATA_BUS_WIDTH = 32;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // MUL is handled as unsigned: its low word does not depend on signedness.
    function automatic logic rs1_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic rs2_is_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH);
    endfunction

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_BUS_WIDTH-1:0] magnitude(
        input logic [DATA_BUS_WIDTH-1:0] x,
        input logic                      neg
    );
        return neg ? ((~x) + {{(DATA_BUS_WIDTH-1){1'b0}}, 1'b1}) : x;
    endfunction

endpackage

// File: rtl/core_exu_mul.sv
// Unsigned-magnitude multiplier; sign_i requests two's-complement negation
// of the full double-width product.
module core_exu_mul #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   data1_i,
    input  logic [XLEN-1:0]   data2_i,
    input  logic              sign_i,
    output logic [2*XLEN-1:0] data_o
);

    logic [2*XLEN-1:0] uprod;

    assign uprod  = {{XLEN{1'b0}}, data1_i} * {{XLEN{1'b0}}, data2_i};
    assign data_o = sign_i ? ((~uprod) + {{(2*XLEN-1){1'b0}}, 1'b1}) : uprod;

endmodule

// File: rtl/core_exu_mul_ctrl.sv
// RV32M multiply sequencer: IDLE -> CALC (one cycle) -> DONE, with a registered
// product held toward writeback, flush support and an issue-stall busy_o.
module core_exu_mul_ctrl
    import core_exu_mul_ctrl_pkg::*;
#(
    parameter int XLEN = DATA_BUS_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            ready_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    // Handshake: a result transfers on any cycle where valid_o && ready_i;
    // while valid_o && !ready_i, result_o holds and start_i is ignored.
    // A new request is taken when start_i && !busy_o && !flush_i.

    state_t            state_q, state_d;
    logic              accept;
    logic              neg1, neg2;
    logic [XLEN-1:0]   mag1_q, mag2_q;
    logic              sign_q;
    logic              hi_sel_q;
    logic [2*XLEN-1:0] prod_q;
    logic [2*XLEN-1:0] mul_data;

    assign accept = start_i && !flush_i &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && ready_i));
    assign neg1   = rs1_is_signed(op_i) & rs1_i[XLEN-1];
    assign neg2   = rs2_is_signed(op_i) & rs2_i[XLEN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_CALC;
                ST_CALC: state_d = ST_DONE;
                ST_DONE: if (ready_i) state_d = start_i ? ST_CALC : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o  = (state_q == ST_CALC) || ((state_q == ST_DONE) && !ready_i);
        valid_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag1_q   <= '0;
            mag2_q   <= '0;
            sign_q   <= 1'b0;
            hi_sel_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            if (accept) begin
                mag1_q   <= magnitude(rs1_i, neg1);
                mag2_q   <= magnitude(rs2_i, neg2);
                sign_q   <= neg1 ^ neg2;
                hi_sel_q <= (op_i != MUL_OP_MUL);
            end
            if (state_q == ST_CALC) begin
                prod_q <= mul_data;
            end
        end
    end

    // The multiplier sees only latched magnitudes, so inputs are free to change after accept.
    core_exu_mul #(
        .XLEN (XLEN)
    ) u_mul (
        .data1_i (mag1_q),
        .data2_i (mag2_q),
        .sign_i  (sign_q),
        .data_o  (mul_data)
    );

    // hi_sel_q only changes on accept, so result_o is stable throughout DONE.
    assign result_o = hi_sel_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];

endmodule

// File: tb/tb_core_exu_mul_ctrl.sv
// Directed bench for the RV32M multiply controller: latency, signed cases,
// backpressure, back-to-back issue, flush and asynchronous reset.
module tb_core_exu_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        flush_i;
    logic        ready_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int checks   = 0;
    int failures = 0;

    core_exu_mul_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        start_i = st;
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
    endtask

    // Issue one op with ready_i high and check the result two cycles later.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        ready_i = 1'b1;
        drive(1'b1, op, a, b);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk({tag, "_valid"}, {31'h0, valid_o}, 32'h1);
        chk({tag, "_result"}, result_o, exp);
        tick();
        chk({tag, "_idle"}, {31'h0, valid_o}, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_valid", {31'h0, valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        rst_n = 1'b1;
        tick();

        // MUL 7 x -3 : latency and busy profile
        ready_i = 1'b1;
        drive(1'b1, 2'b00, 32'd7, 32'hFFFF_FFFD);
        #1;
        chk("mul_busy_n", {31'h0, busy_o}, 32'h0);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("mul_busy_n1", {31'h0, busy_o}, 32'h1);
        chk("mul_valid_n1", {31'h0, valid_o}, 32'h0);
        tick();
        chk("mul_valid_n2", {31'h0, valid_o}, 32'h1);
        chk("mul_result", result_o, 32'hFFFF_FFEB);
        chk("mul_busy_n2", {31'h0, busy_o}, 32'h0);
        tick();
        chk("mul_idle", {31'h0, valid_o}, 32'h0);

        run_op("mulh_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_neg", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_zero", 2'b01, 32'h0, 32'h8000_0000, 32'h0);
        run_op("mulh_neg", 2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        // Backpressure: hold DONE for 5 cycles, stray start ignored
        ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'd2, 32'h10);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            else drive(1'b0, 2'b00, 32'h0, 32'h0);
            #1;
            chk("bp_valid", {31'h0, valid_o}, 32'h1);
            chk("bp_result", result_o, 32'h20);
            chk("bp_busy", {31'h0, busy_o}, 32'h1);
            tick();
        end
        // Release with a back-to-back MULHU 3 x 5
        ready_i = 1'b1;
        drive(1'b1, 2'b11, 32'd3, 32'd5);
        #1;
        chk("b2b_accept_busy", {31'h0, busy_o}, 32'h0);
        chk("b2b_accept_result", result_o, 32'h20);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("b2b_calc_valid", {31'h0, valid_o}, 32'h0);
        chk("b2b_calc_busy", {31'h0, busy_o}, 32'h1);
        tick();
        chk("b2b_valid", {31'h0, valid_o}, 32'h1);
        chk("b2b_result", result_o, 32'h0);
        tick();

        // Flush during CALC: no result appears
        drive(1'b1, 2'b00, 32'd2, 32'd3);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_calc_valid", {31'h0, valid_o}, 32'h0);
        chk("flush_calc_busy", {31'h0, busy_o}, 32'h0);
        tick();
        chk("flush_calc_valid2", {31'h0, valid_o}, 32'h0);

        // Flush together with start in IDLE: nothing launched
        drive(1'b1, 2'b00, 32'd4, 32'd4);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        chk("flush_idle_busy", {31'h0, busy_o}, 32'h0);
        tick();
        chk("flush_idle_valid", {31'h0, valid_o}, 32'h0);

        // Flush in DONE under backpressure drops the held result
        ready_i = 1'b0;
        drive(1'b1, 2'b00, 32'd9, 32'd9);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        tick();
        chk("flush_done_pre", result_o, 32'd81);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_done_valid", {31'h0, valid_o}, 32'h0);
        chk("flush_done_busy", {31'h0, busy_o}, 32'h0);

        // Asynchronous reset in the middle of CALC
        ready_i = 1'b1;
        drive(1'b1, 2'b01, 32'd4, 32'd5);
        tick();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'h0, valid_o}, 32'h0);
        chk("arst_result", result_o, 32'h0);
        chk("arst_busy", {31'h0, busy_o}, 32'h0);
        tick();
        chk("arst_hold_valid", {31'h0, valid_o}, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("arst_after_valid", {31'h0, valid_o}, 32'h0);
        run_op("post_rst_mul", 2'b00, 32'd2, 32'd3, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
